// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC redirect/stall controls, instruction memory port and the
// IF/ID register outputs that feed decode.
interface instr_fetch_if;
   logic        stall;
   logic        flush;
   logic [31:0] target_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] PC_out;
   logic [31:0] instruction_out;
   logic        valid_out;
   logic        halted;

   // master: the fetch unit; slave: hazard logic, imem and decode around it
   modport master (
      input  stall, flush, target_pc, imem_rdata,
      output imem_addr, PC_out, instruction_out, valid_out, halted
   );
   modport slave (
      output stall, flush, target_pc, imem_rdata,
      input  imem_addr, PC_out, instruction_out, valid_out, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, START/RUN/HALT FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance counters.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
   parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]    fetch_cnt,
   output logic [31:0]    bubble_cnt
`endif
);

   typedef enum logic [1:0] {START, RUN, HALT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   ifid_t       ifid, ifid_nxt;
   logic        fetch_evt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= START;
         pc    <= RESET_PC;
         ifid  <= '{32'h0, NOP_INSTR, 1'b0};
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ifid  <= ifid_nxt;
      end
   end

   // Redirect beats everything; stall freezes START/RUN but HALT ignores it.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ifid_nxt  = ifid;
      fetch_evt = 1'b0;
      if (bus.flush) begin
         pc_nxt         = {bus.target_pc[31:2], 2'b00};
         ifid_nxt.instr = NOP_INSTR;
         ifid_nxt.valid = 1'b0;
         state_nxt      = RUN;
      end else begin
         case (state)
            START: begin
               if (!bus.stall) begin
                  ifid_nxt  = '{pc, NOP_INSTR, 1'b0};
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (!bus.stall) begin
                  ifid_nxt  = '{pc, bus.imem_rdata, 1'b1};
                  fetch_evt = 1'b1;
                  if (bus.imem_rdata == HALT_INSTR) state_nxt = HALT;
                  else                              pc_nxt    = pc + 32'd4;
               end
            end
            HALT: begin
               ifid_nxt = '{pc, NOP_INSTR, 1'b0};
            end
            default: begin
               state_nxt = START;
            end
         endcase
      end
   end

   assign bus.imem_addr       = pc;
   assign bus.PC_out          = ifid.pc;
   assign bus.instruction_out = ifid.instr;
   assign bus.valid_out       = ifid.valid;
   assign bus.halted          = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
   // Every non-reset cycle is either a real fetch or a bubble (START, stall, flush, HALT).
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt  <= 32'h0;
         bubble_cnt <= 32'h0;
      end else if (fetch_evt) begin
         fetch_cnt  <= fetch_cnt + 32'd1;
      end else begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a transaction-level fetch model predicts the
// IF/ID contents after every clock; a negedge monitor compares against the DUT.
module tb_instr_fetch;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_if bus ();
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, bubble_cnt;
`endif

   instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .HALT_INSTR(HALT_INSTR)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   logic [31:0] mem [256];
   always_comb bus.imem_rdata = mem[bus.imem_addr[9:2]];

   typedef struct {
      logic [31:0] pc_out, ins, addr, fc, bc;
      logic        v, h;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model: where the fetch pointer is and what decode should see.
   logic [31:0] m_pc, m_pco, m_ins, m_fc, m_bc;
   bit          m_v, m_fresh, m_halted;

   task automatic model(input bit r, input bit s, input bit f, input logic [31:0] t);
      logic [31:0] w;
      if (r) begin
         m_pc = RESET_PC; m_pco = 32'h0; m_ins = NOP_INSTR; m_v = 1'b0;
         m_fresh = 1'b1; m_halted = 1'b0; m_fc = 0; m_bc = 0;
      end else if (f) begin
         m_pc = t & ~32'h3; m_ins = NOP_INSTR; m_v = 1'b0;
         m_fresh = 1'b0; m_halted = 1'b0; m_bc++;
      end else if (m_halted) begin
         m_pco = m_pc; m_ins = NOP_INSTR; m_v = 1'b0; m_bc++;
      end else if (s) begin
         m_bc++;
      end else if (m_fresh) begin
         m_pco = m_pc; m_ins = NOP_INSTR; m_v = 1'b0; m_fresh = 1'b0; m_bc++;
      end else begin
         w = mem[m_pc[9:2]];
         m_pco = m_pc; m_ins = w; m_v = 1'b1; m_fc++;
         if (w == HALT_INSTR) m_halted = 1'b1;
         else                 m_pc = m_pc + 4;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit f, input logic [31:0] t);
      exp_t e;
      @(negedge clk); #1;
      reset = r; bus.stall = s; bus.flush = f; bus.target_pc = t;
      model(r, s, f, t);
      e.pc_out = m_pco; e.ins = m_ins; e.addr = m_pc; e.v = m_v; e.h = m_halted;
      e.fc = m_fc; e.bc = m_bc;
      @(posedge clk); #1;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("PC_out", bus.PC_out, e.pc_out);
         chk("instruction_out", bus.instruction_out, e.ins);
         chk("valid_out", {31'h0, bus.valid_out}, {31'h0, e.v});
         chk("halted", {31'h0, bus.halted}, {31'h0, e.h});
         chk("imem_addr", bus.imem_addr, e.addr);
`ifdef FETCH_PERF_CNT_EN
         chk("fetch_cnt", fetch_cnt, e.fc);
         chk("bubble_cnt", bubble_cnt, e.bc);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.target_pc = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0010_0093 + i;

      // reset, START bubble, fetch 0/4, stall twice at 8, resume
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 1, 0, 0); step(0, 1, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      // flush + stall together with misaligned target
      step(0, 1, 1, 32'h0000_0043);
      step(0, 0, 0, 0); step(0, 0, 0, 0);

      // ecall at PC 12: halt, stall ignored, flush to 0x20 resumes
      mem[3] = HALT_INSTR;
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0020);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      mem[3] = 32'h0010_0093 + 3;

      // PC wrap past the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

      // counter scenario: START + 3 fetches + stall + flush
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0080);

      // randomized traffic with sprinkled ecalls and resets
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? HALT_INSTR : 32'($urandom);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, 32'($urandom));

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h00000013: bubble instruction (addi x0,x0,0).
REQ-003 The module SHALL have parameter HALT_INSTR, default 32'h00000073: instruction (ecall) that halts fetch.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Port `clk` SHALL be an input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 Port `reset` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-007 Port `stall` SHALL be an input, 1 bit: load-use hazard; hold PC and IF/ID.
REQ-008 Port `flush` SHALL be an input, 1 bit: taken branch/jal/jalr resolved downstream; redirect fetch.
REQ-009 Port `target_pc` SHALL be an input, 32 bits: redirect address, valid when flush=1.
REQ-010 Port `imem_addr` SHALL be an output, 32 bits: instruction memory address, combinationally equal to the current PC.
REQ-011 Port `imem_rdata` SHALL be an input, 32 bits: instruction word at imem_addr, combinational, same cycle.
REQ-012 Port `PC_out` SHALL be an output, 32 bits: IF/ID register PC, feeding the decode stage's PC_in.
REQ-013 Port `instruction_out` SHALL be an output, 32 bits: IF/ID register instruction, feeding the decode stage's instruction_in.
REQ-014 Port `valid_out` SHALL be an output, 1 bit: IF/ID holds a real fetched instruction (0 = bubble).
REQ-015 Port `halted` SHALL be an output, 1 bit: FSM is in HALT.

Function
REQ-016 The FSM SHALL have states START, RUN and HALT; the 32-bit PC register SHALL always be 4-byte aligned.
REQ-017 Update priority each cycle SHALL be reset > flush > stall > state action.
REQ-018 START (first cycle after reset): PC holds; IF/ID loads {PC_out=PC, instruction_out=NOP_INSTR, valid_out=0}; next state RUN.
REQ-019 RUN, no stall/flush: IF/ID loads {PC, imem_rdata, 1}; PC <= PC+4, giving 1-cycle fetch latency.
REQ-020 RUN, imem_rdata==HALT_INSTR: the HALT_INSTR word SHALL be latched into IF/ID with valid 1; PC holds; next state HALT.
REQ-021 HALT: PC holds; IF/ID loads {PC, NOP_INSTR, 0} every cycle; halted=1; stall ignored.
REQ-022 flush in any non-reset state: PC <= {target_pc[31:2],2'b00}; IF/ID loads {PC_out unchanged, NOP_INSTR, 0}; next state RUN (HALT exits on flush).
REQ-023 flush and stall together: flush SHALL win; stall is discarded.
REQ-024 stall in RUN without flush: PC, IF/ID and state SHALL be unchanged, and a HALT_INSTR at imem_rdata SHALL NOT be acted on.
REQ-025 PC increment SHALL be modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
REQ-026 A misaligned target_pc SHALL be silently truncated to word alignment.

Reset
REQ-027 While reset=1: PC <= RESET_PC; PC_out <= 0; instruction_out <= NOP_INSTR; valid_out <= 0; state <= START; halted=0.
REQ-028 Reset asserted mid-stall, mid-flush or in HALT SHALL override all other inputs in that cycle.
REQ-029 imem_addr SHALL equal RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: the module SHALL add outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
REQ-031 With FETCH_PERF_CNT_EN defined: fetch_cnt SHALL increment on each cycle IF/ID loads valid 1.
REQ-032 With FETCH_PERF_CNT_EN defined: bubble_cnt SHALL increment on each non-reset cycle IF/ID loads valid 0 or is held by stall.
REQ-033 With FETCH_PERF_CNT_EN defined: both counters SHALL wrap at 2^32.
REQ-034 Macro FETCH_PERF_CNT_EN undefined: the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL cover reset then sequential imem (word n = 32'h00100093+n): cycle1 valid_out=0; then PC_out=0,4,8 with matching instructions and valid_out=1.
REQ-036 The bench SHALL cover stall held 2 cycles at PC=8: PC_out and instruction_out stay frozen, imem_addr stays 8, and fetch resumes at 8 afterwards.
REQ-037 The bench SHALL cover flush with target_pc=32'h00000043 at the same time as stall: the next cycle gives instruction_out=NOP_INSTR, valid_out=0, imem_addr=32'h40.
REQ-038 The bench SHALL cover imem returning 32'h00000073 at PC=12: IF/ID gets ecall with valid 1, then halted=1, NOPs follow, PC stays 12, and a later flush to 32'h20 resumes RUN.
REQ-039 The bench SHALL cover flush to 32'hFFFFFFFC: the next fetch address is 32'h00000000 (wrap).
REQ-040 The bench SHALL cover, with FETCH_PERF_CNT_EN defined, 3 fetches + 1 stall + 1 flush after reset: fetch_cnt=3 and bubble_cnt=3 (START+stall+flush).
